// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin request/acknowledge arbiter that shares one
// single-port block RAM among CORE_CNT cores. One access is in flight at a
// time; write acks in the ISSUE cycle, read acks with registered read data.
module mem_arbiter #(
    parameter int ADDR_WID = 32,
    parameter int DATA_WID = 32,
    parameter int CORE_CNT = 16,
    parameter int RD_LAT   = 1,
    localparam int IDX_W   = $clog2(CORE_CNT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CORE_CNT-1:0]          req,
    input  logic [CORE_CNT-1:0]          req_we,
    input  logic [CORE_CNT*ADDR_WID-1:0] req_addr,
    input  logic [CORE_CNT*DATA_WID-1:0] req_wdata,
    output logic [CORE_CNT-1:0]          ack,
    output logic [DATA_WID-1:0]          rdata,
    output logic                         busy,
    output logic [IDX_W-1:0]             owner,
    output logic                         mem_en,
    output logic [3:0]                   mem_we,
    output logic [ADDR_WID-1:0]          mem_addr,
    output logic [DATA_WID-1:0]          mem_wdata,
    input  logic [DATA_WID-1:0]          mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]          state;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    ptr_nxt;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_vld;
    logic                we_q;
    logic                rd_ack_q;   // read completes: ack + rdata in the IDLE-return cycle
    logic [1:0]          cnt;        // WAIT cycles left, including the current one
    logic                ack_fire;
    logic [CORE_CNT-1:0] owner_oh;

    // Round-robin pick: first requesting core at ptr, ptr+1, ... wrapping.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel_vld = |req;
        sel_idx = '0;
        cand    = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins last.
        for (int i = CORE_CNT - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr) + i) % CORE_CNT);
            if (req[cand]) begin
                sel_idx = cand;
            end
        end
    end

    // Output decode: write ack in ISSUE, read ack one cycle after RESP.
    always_comb begin
        owner_oh = {{(CORE_CNT-1){1'b0}}, 1'b1} << owner;
        ack_fire = ((state == S_ISSUE) && we_q) || rd_ack_q;
        ack      = ack_fire ? owner_oh : '0;
        mem_en   = (state == S_ISSUE);
        mem_we   = mem_en ? {4{we_q}} : 4'b0000;
        busy     = (state != S_IDLE);
        ptr_nxt  = (owner == IDX_W'(CORE_CNT - 1)) ? '0 : owner + IDX_W'(1);
    end

    // Access FSM, latched request copy, pointer advance and read data capture.
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner     <= '0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= 2'd0;
            rd_ack_q  <= 1'b0;
            rdata     <= '0;
        end else begin
            rd_ack_q <= 1'b0;
            if (ack_fire) begin
                ptr <= ptr_nxt;
            end
            case (state)
                S_IDLE: begin
                    // The read-ack cycle is not a grant cycle; the next
                    // decision is made in the cycle after any ack.
                    if (sel_vld && !rd_ack_q) begin
                        owner     <= sel_idx;
                        we_q      <= req_we[sel_idx];
                        mem_addr  <= req_addr[int'(sel_idx)*ADDR_WID +: ADDR_WID];
                        mem_wdata <= req_wdata[int'(sel_idx)*DATA_WID +: DATA_WID];
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (we_q) begin
                        state <= S_IDLE;
                    end else if (RD_LAT == 1) begin
                        state <= S_RESP;
                    end else begin
                        cnt   <= 2'(RD_LAT - 1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    rdata    <= mem_rdata;
                    rd_ack_q <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks plus a randomized run checked against a
// transaction-level round-robin model. A second instance covers RD_LAT=3.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NC = 4;
    localparam int RL = 1;
    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NC-1:0]    req, req_we, ack;
    logic [NC*AW-1:0] req_addr;
    logic [NC*DW-1:0] req_wdata;
    logic [DW-1:0]    rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]    mem_addr;
    logic             busy, mem_en;
    logic [1:0]       owner;
    logic [3:0]       mem_we;

    logic [NC-1:0]    req3, req_we3, ack3;
    logic [NC*AW-1:0] req_addr3;
    logic [NC*DW-1:0] req_wdata3;
    logic [DW-1:0]    rdata3, mem_wdata3, mem_rdata3;
    logic [AW-1:0]    mem_addr3;
    logic             busy3, mem_en3;
    logic [1:0]       owner3;
    logic [3:0]       mem_we3;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_WID(AW), .DATA_WID(DW), .CORE_CNT(NC), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .busy(busy), .owner(owner),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_WID(AW), .DATA_WID(DW), .CORE_CNT(NC), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .req_we(req_we3), .req_addr(req_addr3),
        .req_wdata(req_wdata3), .ack(ack3), .rdata(rdata3), .busy(busy3), .owner(owner3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {26'd0, a[5:0]};
    endfunction

    // RAM behind dut: 64 words, unwritten words read as init_word(addr).
    // Read data is valid only in the single cycle RD_LAT after ISSUE.
    bit [31:0] ram [64];
    bit        ram_vld [64];
    always @(posedge clk) begin
        if (mem_en && mem_we == 4'hF) begin
            ram[mem_addr[5:0]]     <= mem_wdata;
            ram_vld[mem_addr[5:0]] <= 1'b1;
        end
        if (mem_en && mem_we == 4'h0)
            mem_rdata <= ram_vld[mem_addr[5:0]] ? ram[mem_addr[5:0]] : init_word(mem_addr);
        else
            mem_rdata <= BAD;
    end

    // Read-only RAM behind dut3 with a 3-stage read pipeline.
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        p3[0] <= mem_en3 ? init_word(mem_addr3) : BAD;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata3 = p3[2];

    task automatic drive_idle();
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        req3 = '0; req_we3 = '0; req_addr3 = '0; req_wdata3 = '0;
    endtask

    task automatic set_req(input int core, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        req[core] = 1'b1;
        req_we[core] = we;
        req_addr[core*AW +: AW] = addr;
        req_wdata[core*DW +: DW] = wdata;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Bounded wait for an ack; k = negedges elapsed (-1 on timeout).
    task automatic wait_ack(input bit on3, output int k, output int en_cnt);
        k = -1;
        en_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (on3 ? mem_en3 : mem_en) en_cnt++;
            if ((on3 ? ack3 : ack) != '0) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int k, e;
        @(negedge clk);
        checks++;
        if ({ack, rdata, busy, owner, mem_en, mem_we, mem_addr, mem_wdata} !== '0)
            $display("FAIL reset_state: got %h required 0",
                     {ack, rdata, busy, owner, mem_en, mem_we, mem_addr, mem_wdata});
        checks++;
        if ({ack3, rdata3, busy3, owner3, mem_en3, mem_we3, mem_addr3, mem_wdata3} !== '0)
            $display("FAIL reset_state_lat3: got %h required 0",
                     {ack3, rdata3, busy3, owner3, mem_en3, mem_we3, mem_addr3, mem_wdata3});
        errors += ((ack !== 0 || rdata !== 0 || busy !== 0 || owner !== 0 || mem_en !== 0 ||
                    mem_we !== 0 || mem_addr !== 0 || mem_wdata !== 0) ? 1 : 0);
        errors += ((ack3 !== 0 || rdata3 !== 0 || busy3 !== 0 || owner3 !== 0 || mem_en3 !== 0 ||
                    mem_we3 !== 0 || mem_addr3 !== 0 || mem_wdata3 !== 0) ? 1 : 0);
        rst = 1'b0;
        // Complete one read so rdata and ptr are non-zero before the abort.
        set_req(1, 1'b0, 32'd9, 32'd0);
        wait_ack(1'b0, k, e);
        drive_idle();
        checks++;
        if (k !== 3) begin errors++; $display("FAIL pre_reset_read_lat: got %0d required 3", k); end
        checks++;
        if (rdata !== init_word(9)) begin
            errors++; $display("FAIL pre_reset_rdata: got %h required %h", rdata, init_word(9));
        end
        @(negedge clk);
        // Start a read and reset in its ISSUE cycle.
        set_req(2, 1'b0, 32'd42, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        #1;
        checks++;
        if ({ack, rdata, busy, owner, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mid_read: got %h required 0",
                     {ack, rdata, busy, owner, mem_en, mem_we, mem_addr, mem_wdata});
        end
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000) begin errors++; $display("FAIL reset_no_ack: got %b required 0000", ack); end
        rst = 1'b0;
        for (int c = 0; c < NC; c++) set_req(c, 1'b1, 32'(c), 32'h1111_0000 + 32'(c));
        wait_ack(1'b0, k, e);
        checks++;
        if (k !== 1 || ack !== 4'b0001 || owner !== 2'd0) begin
            errors++;
            $display("FAIL reset_next_grant: got k=%0d ack=%b owner=%0d required k=1 ack=0001 owner=0",
                     k, ack, owner);
        end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_single_write();
        set_req(2, 1'b1, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 4'hF) begin
            errors++; $display("FAIL wr_mem_en_we: got en=%b we=%h required en=1 we=f", mem_en, mem_we);
        end
        checks++;
        if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_addr_data: got %h/%h required 00000010/deadbeef", mem_addr, mem_wdata);
        end
        checks++;
        if (ack !== 4'b0100) begin errors++; $display("FAIL wr_ack: got %b required 0100", ack); end
        drive_idle();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ack !== 4'b0000 || owner !== 2'd2) begin
            errors++;
            $display("FAIL wr_after: got busy=%b ack=%b owner=%0d required busy=0 ack=0000 owner=2",
                     busy, ack, owner);
        end
    endtask

    task automatic test_read_back();
        int k, e;
        set_req(2, 1'b0, 32'h10, 32'd0);
        wait_ack(1'b0, k, e);
        checks++;
        if (k !== 3) begin errors++; $display("FAIL rd_latency: got %0d required 3", k); end
        checks++;
        if (ack !== 4'b0100) begin errors++; $display("FAIL rd_ack: got %b required 0100", ack); end
        checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd_data: got %h required deadbeef", rdata);
        end
        checks++;
        if (e !== 1) begin errors++; $display("FAIL rd_mem_en_cycles: got %0d required 1", e); end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_contention();
        int k, e, lat;
        bit we [NC];
        apply_reset();
        for (int c = 0; c < NC; c++) begin
            we[c] = 1'($urandom_range(1));
            set_req(c, we[c], 32'(c), $urandom);
        end
        for (int n = 0; n < 5; n++) begin
            lat = we[n % NC] ? 1 : RL + 2;
            wait_ack(1'b0, k, e);
            checks++;
            if (k !== ((n == 0) ? lat : lat + 1)) begin
                errors++;
                $display("FAIL cont_gap_%0d: got %0d required %0d", n, k, (n == 0) ? lat : lat + 1);
            end
            checks++;
            if (ack !== 4'(1 << (n % NC)) || owner !== 2'(n % NC)) begin
                errors++;
                $display("FAIL cont_grant_%0d: got ack=%b owner=%0d required owner=%0d",
                         n, ack, owner, n % NC);
            end
        end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_skip_idle();
        int k, e;
        apply_reset();
        set_req(0, 1'b1, 32'h4, 32'h0000_0A0A);
        wait_ack(1'b0, k, e);
        set_req(3, 1'b1, 32'h5, 32'h0000_0B0B);
        wait_ack(1'b0, k, e);
        checks++;
        if (k !== 2 || ack !== 4'b1000 || owner !== 2'd3) begin
            errors++;
            $display("FAIL skip_first: got k=%0d ack=%b owner=%0d required k=2 ack=1000 owner=3",
                     k, ack, owner);
        end
        wait_ack(1'b0, k, e);
        checks++;
        if (k !== 2 || ack !== 4'b0001 || owner !== 2'd0) begin
            errors++;
            $display("FAIL skip_wrap: got k=%0d ack=%b owner=%0d required k=2 ack=0001 owner=0",
                     k, ack, owner);
        end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_rd_lat3();
        int k, e;
        req3[1] = 1'b1;
        req_we3[1] = 1'b0;
        req_addr3[1*AW +: AW] = 32'd5;
        wait_ack(1'b1, k, e);
        checks++;
        if (k !== 5) begin errors++; $display("FAIL lat3_latency: got %0d required 5", k); end
        checks++;
        if (e !== 1) begin errors++; $display("FAIL lat3_mem_en_cycles: got %0d required 1", e); end
        checks++;
        if (ack3 !== 4'b0010 || rdata3 !== init_word(5)) begin
            errors++;
            $display("FAIL lat3_ack_data: got ack=%b rdata=%h required 0010/%h", ack3, rdata3, init_word(5));
        end
        drive_idle();
        @(negedge clk);
    endtask

    // Randomized traffic on addresses 32..63 against a transaction-level model:
    // a decision slot opens, the first pending core from ptr wins, the ack lands
    // a fixed latency later, and the next slot opens the cycle after the ack.
    task automatic test_random();
        bit          pend [NC];
        bit          p_we [NC];
        logic [31:0] p_addr [NC];
        logic [31:0] p_wdata [NC];
        bit   [31:0] mdl [64];
        bit          mvld [64];
        int          next_free = 1, ack_cyc = -1, busy_end = 0, g = 0, m_ptr = 0, own = 0, found;
        bit          own_we = 1'b0;
        logic [31:0] exp_rd = '0, hold = '0;
        logic [3:0]  exp_ack;
        logic        exp_busy;
        logic [5:0]  a;
        apply_reset();
        for (int k = 0; k < NC; k++) pend[k] = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            exp_ack  = (c == ack_cyc) ? 4'(1 << own) : 4'b0000;
            exp_busy = (c > g) && (c <= busy_end);
            checks++;
            if (ack !== exp_ack) begin
                errors++; $display("FAIL rnd_ack c=%0d: got %b required %b", c, ack, exp_ack);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++; $display("FAIL rnd_busy c=%0d: got %b required %b", c, busy, exp_busy);
            end
            if (c == ack_cyc) begin
                checks++;
                if (owner !== 2'(own)) begin
                    errors++; $display("FAIL rnd_owner c=%0d: got %0d required %0d", c, owner, own);
                end
                if (!own_we) hold = exp_rd;
                pend[own] = 1'b0;
            end
            checks++;
            if (rdata !== hold) begin
                errors++; $display("FAIL rnd_rdata c=%0d: got %h required %h", c, rdata, hold);
            end
            for (int k = 0; k < NC; k++) begin
                if (!pend[k] && $urandom_range(2) == 0) begin
                    pend[k]    = 1'b1;
                    p_we[k]    = 1'($urandom_range(1));
                    p_addr[k]  = 32'(32 + $urandom_range(31));
                    p_wdata[k] = $urandom;
                end
                req[k] = pend[k];
                req_we[k] = p_we[k];
                req_addr[k*AW +: AW] = p_addr[k];
                req_wdata[k*DW +: DW] = p_wdata[k];
            end
            if (c == next_free) begin
                found = -1;
                for (int i = 0; i < NC; i++)
                    if (found < 0 && pend[(m_ptr + i) % NC]) found = (m_ptr + i) % NC;
                if (found >= 0) begin
                    own    = found;
                    own_we = p_we[found];
                    g      = c;
                    a      = p_addr[found][5:0];
                    if (own_we) begin
                        mdl[a]    = p_wdata[found];
                        mvld[a]   = 1'b1;
                        ack_cyc   = c + 1;
                        busy_end  = c + 1;
                        next_free = c + 2;
                    end else begin
                        exp_rd    = mvld[a] ? mdl[a] : init_word(32'(a));
                        ack_cyc   = c + RL + 2;
                        busy_end  = c + RL + 1;
                        next_free = c + RL + 3;
                    end
                    m_ptr = (found + 1) % NC;
                end else begin
                    next_free = c + 1;
                end
            end
        end
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_skip_idle();
        test_rd_lat3();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
